// File: rtl/pc_ctrl.sv
// Program-counter controller: byte stepping, JUN/JCN, and JMS/BBL sequencing
// against the external call stack.
module pc_ctrl #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        opValid,
  input  logic [2:0]  op,
  input  logic [11:0] target,
  input  logic        cond,
  output logic [11:0] pc,
  output logic        busy,
  output logic        fault,
  output logic        stackPush,
  output logic        stackPop,
  output logic [11:0] stackPcIn,
  input  logic [11:0] stackPcOut,
  input  logic        stackOverflow,
  input  logic        stackUnderflow
);

  localparam logic [2:0] OP_JUN = 3'd1;
  localparam logic [2:0] OP_JCN = 3'd2;
  localparam logic [2:0] OP_JMS = 3'd3;
  localparam logic [2:0] OP_BBL = 3'd4;

  typedef enum logic [1:0] {IDLE, CALL, POP, LOAD} state_t;

  state_t      r_state, w_next;
  logic [11:0] r_pc, w_pc_nxt;
  logic [11:0] r_tgt;
  logic [11:0] r_pcin;
  logic        r_busy;
  logic        r_fault;
  logic        w_latch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_tgt   <= 12'h000;
      r_pcin  <= 12'h000;
      r_busy  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_nxt;
      r_busy  <= (w_next != IDLE);
      r_fault <= r_fault | stackOverflow | stackUnderflow;
      if (w_latch) begin
        r_tgt  <= target;
        r_pcin <= r_pc;
      end
    end
  end

  // Requests are only looked at in IDLE; anything arriving while busy is dropped.
  always_comb begin
    w_next   = r_state;
    w_pc_nxt = r_pc;
    w_latch  = 1'b0;
    case (r_state)
      IDLE: begin
        if (opValid && op == OP_JUN) begin
          w_pc_nxt = target;
        end else if (opValid && op == OP_JCN) begin
          if (cond) w_pc_nxt = {r_pc[11:8], target[7:0]};
        end else if (opValid && op == OP_JMS) begin
          w_latch = 1'b1;
          w_next  = CALL;
        end else if (opValid && op == OP_BBL) begin
          w_next = POP;
        end else if (step) begin
          w_pc_nxt = r_pc + 12'd1;
        end
      end
      CALL: begin
        w_pc_nxt = r_tgt;
        w_next   = IDLE;
      end
      POP:  w_next = LOAD;
      LOAD: begin
        w_pc_nxt = stackPcOut;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign pc        = r_pc;
  assign busy      = r_busy;
  assign fault     = r_fault;
  assign stackPush = (r_state == CALL);
  assign stackPop  = (r_state == POP);
  assign stackPcIn = r_pcin;

endmodule
